ame_pivot_sched: RTL
====================

Name: ame_pivot_sched

Overview:
- Column-by-column partial-pivot scheduler for the affine motion-estimation 6x6 linear solver.
- For each column it reads the column from the coefficient matrix buffer and forms absolute values of the still-unpivoted rows. It launches the 6-lane max comparator (1-cycle registered, init/done handshake) and hands the winning row index to the downstream row-swap/elimination engine via valid/ready.
- Sits between the matrix buffer, the comparator instance and the elimination engine.

Parameters:
- COMP_DATA_BITS, 64, width of one matrix element (signed two's complement).
- COMP_DATA_IDX_BITS, 3, width of row/column indices.
- ROW_NUM, 6, active system size, legal 2..6; lanes >= ROW_NUM are always masked.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- sched_start_i  in  1  start a pivot pass; ignored while busy.
- sched_busy_o  out  1  high from the cycle after accepted start until done.
- sched_done_o  out  1  one-cycle pulse at end of pass.
- sched_sing_o  out  1  sticky singular flag for the current pass; cleared on the next accepted start.
- mat_rd_en_o  out  1  column read strobe, one cycle.
- mat_rd_col_o  out  IDX_BITS  column index k being read.
- mat_rd_data_i  in  6xCOMP_DATA_BITS  full column, valid exactly 1 cycle after mat_rd_en_o.
- comp_init_o  out  1  comparator launch, one-cycle pulse.
- comp_data_o  out  6xCOMP_DATA_BITS  comparator lane inputs, held stable while waiting.
- comp_done_i  in  1  comparator result valid.
- comp_data_i  in  COMP_DATA_BITS  comparator max value.
- comp_data_idx_i  in  IDX_BITS  comparator max lane.
- piv_valid_o  out  1  pivot record valid.
- piv_ready_i  in  1  downstream accepts pivot record.
- piv_col_o  out  IDX_BITS  column k.
- piv_idx_o  out  IDX_BITS  pivot row.
- piv_data_o  out  COMP_DATA_BITS  pivot magnitude.

Behaviour:
- Reset: all outputs 0; state IDLE; k=0.
- States: IDLE -> RD -> LOAD -> CMP -> WAIT -> OUT -> (RD with k+1 | FIN) -> IDLE.
- IDLE:
  - Start accepted here only: k<=0, sing<=0, go to RD.
  - busy rises the next cycle.
- RD: mat_rd_en_o=1, mat_rd_col_o=k for one cycle.
- LOAD:
  - Capture mat_rd_data_i.
  - Lane i = |data[i]| if k <= i < ROW_NUM, else 0.
  - Abs of the most negative value saturates to 2^(COMP_DATA_BITS-1)-1.
- CMP: comp_init_o=1 for one cycle; comp_data_o held from LOAD through WAIT.
- WAIT:
  - Stay until comp_done_i. comp_done_i outside WAIT is ignored.
  - On done: if comp_data_i==0, sing<=1, pivot idx <= k, data <= 0.
  - Else pivot idx <= comp_data_idx_i, data <= comp_data_i.
  - Masked lanes hold 0 and so can only be reported on the zero path, which overrides idx to k.
- OUT:
  - piv_valid_o=1; piv_* held stable until piv_ready_i.
  - On valid&&ready: if k==ROW_NUM-1 go to FIN, else k++ and go to RD.
  - ready asserted before valid has no effect.
- FIN: sched_done_o=1 for one cycle; busy drops the same cycle; return to IDLE.
- Latency, column k: RD at t, LOAD t+1, CMP t+2, done t+3, OUT valid t+4.
  - With ready held high, each column takes 5 cycles.
  - A full 6x6 pass is 30 cycles plus 1 FIN cycle.
- Simultaneous events:
  - start in the same cycle as FIN is ignored; the team issues it after done.
  - Reset mid-pass returns to IDLE with all outputs 0, including valid and sing.

Optional Feature:
- Macro AME_PIVOT_EARLY_ABORT_EN.
- Defined: a singular column still emits its pivot record (idx=k, data=0). After that handshake the block goes straight to FIN regardless of k; no further columns are read.
- Undefined: all ROW_NUM columns are always processed and sing remains sticky.

Test Plan:
- Identity-scaled matrix, diag = 5,7,9,11,13,15, ready high -> piv_idx 0..5 in order, data = diag values, no sing, done at 31 cycles after start.
- Column 0 = {3,-20,4,1,0,2} -> pivot (col 0, idx 1, data 20). Column 1 rows 1..5 = {0,-8,8,2,1} -> idx 2 or 3 (both 8, data 8) and never 0 or 1.
- Column 2 rows 2..5 all zero, rows 0/1 = 99 -> sing=1, piv_idx=2, data=0; masked rows ignored.
  - Without the macro: 6 records.
  - With AME_PIVOT_EARLY_ABORT_EN: 3 records, then done.
- Element = 0x8000_0000_0000_0000 in an active lane -> data 0x7FFF_FFFF_FFFF_FFFF, idx of that row.
- piv_ready_i low for 10 cycles during column 3 -> piv_* stable, no mat_rd_en_o. Once ready rises, column 4 read follows the next cycle.
- rst_n_i pulsed low in WAIT of column 2 -> all outputs 0 immediately. A new start runs from column 0 with sing cleared; start while busy has no effect.

Source files
------------

// File: rtl/ame_pivot_sched_if.sv
// Signal bundle between the pivot scheduler and its neighbours: matrix buffer,
// 6-lane max comparator and row-swap/elimination engine. The scheduler takes
// the master side; everything else uses the slave side.
interface ame_pivot_sched_if #(
    parameter int COMP_DATA_BITS     = 64,
    parameter int COMP_DATA_IDX_BITS = 3
);
    localparam int LANES = 6;

    // pass control
    logic                                    sched_start_i;
    logic                                    sched_busy_o;
    logic                                    sched_done_o;
    logic                                    sched_sing_o;
    // matrix buffer column read
    logic                                    mat_rd_en_o;
    logic [COMP_DATA_IDX_BITS-1:0]           mat_rd_col_o;
    logic [LANES-1:0][COMP_DATA_BITS-1:0]    mat_rd_data_i;
    // comparator
    logic                                    comp_init_o;
    logic [LANES-1:0][COMP_DATA_BITS-1:0]    comp_data_o;
    logic                                    comp_done_i;
    logic [COMP_DATA_BITS-1:0]               comp_data_i;
    logic [COMP_DATA_IDX_BITS-1:0]           comp_data_idx_i;
    // pivot record to the elimination engine
    logic                                    piv_valid_o;
    logic                                    piv_ready_i;
    logic [COMP_DATA_IDX_BITS-1:0]           piv_col_o;
    logic [COMP_DATA_IDX_BITS-1:0]           piv_idx_o;
    logic [COMP_DATA_BITS-1:0]               piv_data_o;

    modport master (
        input  sched_start_i, mat_rd_data_i, comp_done_i, comp_data_i,
               comp_data_idx_i, piv_ready_i,
        output sched_busy_o, sched_done_o, sched_sing_o, mat_rd_en_o,
               mat_rd_col_o, comp_init_o, comp_data_o, piv_valid_o,
               piv_col_o, piv_idx_o, piv_data_o
    );

    modport slave (
        output sched_start_i, mat_rd_data_i, comp_done_i, comp_data_i,
               comp_data_idx_i, piv_ready_i,
        input  sched_busy_o, sched_done_o, sched_sing_o, mat_rd_en_o,
               mat_rd_col_o, comp_init_o, comp_data_o, piv_valid_o,
               piv_col_o, piv_idx_o, piv_data_o
    );
endinterface

// File: rtl/ame_pivot_sched.sv
// Column-by-column partial-pivot scheduler for the affine motion-estimation
// 6x6 solver. For each column k it reads the column, forms saturated absolute
// values of rows k..ROW_NUM-1, runs the external max comparator and hands the
// winning row to the elimination engine over valid/ready.
// Optional feature macro: AME_PIVOT_EARLY_ABORT_EN -- when defined, the pass
// ends right after the pivot record of the first singular column.
module ame_pivot_sched #(
    parameter int COMP_DATA_BITS     = 64,
    parameter int COMP_DATA_IDX_BITS = 3,
    parameter int ROW_NUM            = 6
) (
    input logic               clk_i,
    input logic               rst_n_i,
    ame_pivot_sched_if.master bus
);
    localparam int LANES = 6;
    localparam int DW    = COMP_DATA_BITS;
    localparam int IW    = COMP_DATA_IDX_BITS;

    typedef logic [DW-1:0] elem_t;
    typedef logic [IW-1:0] idx_t;

    localparam elem_t MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam elem_t MAG_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam idx_t  LAST_COL = idx_t'(ROW_NUM - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_CMP  = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_OUT  = 3'd5;
    localparam logic [2:0] ST_FIN  = 3'd6;

    logic [2:0]                 state;
    idx_t                       k;
    logic                       sing;
    logic [LANES-1:0][DW-1:0]   lanes_q;
    logic [LANES-1:0][DW-1:0]   lanes_d;
    idx_t                       piv_idx_q;
    elem_t                      piv_data_q;
    logic                       abort_pass;

    // Magnitude of a two's complement element; the most negative value has no
    // positive counterpart, so it clamps to the largest positive magnitude.
    function automatic elem_t abs_sat(input elem_t v);
        if (v == MOST_NEG) return MAG_MAX;
        return v[DW-1] ? elem_t'(~v + elem_t'(1)) : v;
    endfunction

`ifdef AME_PIVOT_EARLY_ABORT_EN
    // A singular column ends the pass once its record has been handed off.
    assign abort_pass = sing;
`else
    assign abort_pass = 1'b0;
`endif

    // Lane magnitudes for the column on the read bus; already-pivoted rows and
    // lanes beyond the active system size are forced to zero.
    always_comb begin
        // NOTE: default every lane first so no path leaves lanes_d unassigned (latch).
        lanes_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i >= int'(k) && i < ROW_NUM) lanes_d[i] = abs_sat(bus.mat_rd_data_i[i]);
        end
    end

    // Pass sequencer: column counter, comparator operands, pivot record and sticky flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            k          <= '0;
            sing       <= 1'b0;
            lanes_q    <= '0;
            piv_idx_q  <= '0;
            piv_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (bus.sched_start_i) begin
                        k     <= '0;
                        sing  <= 1'b0;
                        state <= ST_RD;
                    end
                end
                ST_RD:   state <= ST_LOAD;
                ST_LOAD: begin
                    lanes_q <= lanes_d;
                    state   <= ST_CMP;
                end
                ST_CMP:  state <= ST_WAIT;
                ST_WAIT: begin
                    if (bus.comp_done_i) begin
                        if (bus.comp_data_i == '0) begin
                            // Zero max: column is singular; report the diagonal row.
                            sing       <= 1'b1;
                            piv_idx_q  <= k;
                            piv_data_q <= '0;
                        end else begin
                            piv_idx_q  <= bus.comp_data_idx_i;
                            piv_data_q <= bus.comp_data_i;
                        end
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.piv_ready_i) begin
                        if (k == LAST_COL || abort_pass) begin
                            state <= ST_FIN;
                        end else begin
                            k     <= k + idx_t'(1);
                            state <= ST_RD;
                        end
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sched_busy_o = (state != ST_IDLE) && (state != ST_FIN);
    assign bus.sched_done_o = (state == ST_FIN);
    assign bus.sched_sing_o = sing;
    assign bus.mat_rd_en_o  = (state == ST_RD);
    assign bus.mat_rd_col_o = (state == ST_RD) ? k : '0;
    assign bus.comp_init_o  = (state == ST_CMP);
    assign bus.comp_data_o  = lanes_q;
    assign bus.piv_valid_o  = (state == ST_OUT);
    assign bus.piv_col_o    = k;
    assign bus.piv_idx_o    = piv_idx_q;
    assign bus.piv_data_o   = piv_data_q;
endmodule
